alu_wb_regfile: RTL and testbench
=================================

Name: alu_wb_regfile

Overview:
Parametrised successor to the combinational result-select/register-write mux of the extended ALU. It captures one ALU result per cycle through a valid/ready handshake and selects the operand by funct code. The result is registered in a single writeback stage and committed to an internal register file. The block provides two forwarding read ports, a priority host write port and event counters. It sits between the parallel ALU units and the operand-fetch stage.

Parameters:
DATA_W, 32, width of results and registers
NUM_REGS, 32, register count; register 0 reads as zero and is never written
ADDR_W, $clog2(NUM_REGS), register address width
CNT_W, 16, width of saturating event counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  result bundle valid
in_ready  out  1  block can accept bundle this cycle
funct  in  6  function code selecting the result
rd  in  ADDR_W  destination register
res_bus  in  6*DATA_W  packed results; slice k = bits [k*DATA_W +: DATA_W], order add, sub, srl, and, or, slt
host_we  in  1  host/debug write strobe, priority over pipeline commit
host_addr  in  ADDR_W  host write address
host_wdata  in  DATA_W  host write data
rs1_addr, rs2_addr  in  ADDR_W  read addresses
rs1_data, rs2_data  out  DATA_W  combinational read data with forwarding
illegal_pulse  out  1  one-cycle pulse when an illegal funct commits
wb_count  out  CNT_W  saturating count of committed legal writes, including rd=0 writes
illegal_count  out  CNT_W  saturating count of committed illegal functs

Behaviour:
- Funct decode, one-hot to slice index:
  - 100000→0 (add), 100010→1 (sub), 000010→2 (srl), 100100→3 (and), 100101→4 (or), 101010→5 (slt).
  - Any other code sets the illegal flag; the data field is don't-care and the entry never writes.
- Writeback stage register holds s1_valid, s1_rd, s1_data and s1_illegal.
- commit = s1_valid && !host_we.
- in_ready = !s1_valid || commit. This is combinational and has no dependency on in_valid.
- Accept = in_valid && in_ready. On accept, the stage loads the decoded bundle and sets s1_valid.
- When commit occurs with no accept, s1_valid clears. Accept and commit in the same cycle give back-to-back throughput of 1 per cycle.
- Latency: a bundle accepted in cycle N commits at the edge ending cycle N+1 if host_we is low. Its value is visible in the register array from cycle N+2.
- Commit actions:
  - Legal and rd≠0: regs[s1_rd] ← s1_data.
  - Legal, any rd: wb_count increments.
  - Illegal: illegal_pulse is 1 in the commit cycle only, illegal_count increments, and no write occurs.
- host_we=1:
  - regs[host_addr] ← host_wdata, unless host_addr=0, which is ignored.
  - The stage holds its contents; in_ready is 0 if s1_valid.
  - The held entry commits on the first cycle host_we is low, so no data is lost.
  - A stalled entry keeps its data. It commits after the host write and wins on the same address.
- Read ports:
  - addr=0 → 0.
  - Else if s1_valid && !s1_illegal && s1_rd==addr → s1_data. Forwarding applies even while stalled.
  - Else regs[addr].
  - Host writes are not forwarded; they become visible the next cycle.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- Reset, asynchronous, may occur mid-operation:
  - All registers clear to 0; s1_valid, s1_illegal and counters clear to 0.
  - illegal_pulse goes to 0, and in_ready goes to 1 once reset deasserts. A pending entry is discarded.
- X on res_bus slices that are not selected must not propagate.

Decomposition:
- Package alu_wb_pkg holds:
  - funct localparams FUNCT_ADD/SUB/SRL/AND/OR/SLT;
  - the enum of slice indices;
  - a decode function that returns {illegal, index}.
- One sub-module is natural: alu_wb_regarray. It holds the NUM_REGS×DATA_W storage, one write port, two async read ports and the r0 rule.
- Forwarding and the handshake stay in the top level.

Test Plan:
- Reset, then accept funct=100000, rd=5, add slice 0x0000_0007. The read on rs1=5 gives 7 from cycle N+1 via forwarding and from the array from N+2. wb_count=1.
- Back-to-back: sub, rd=3, result 0xFFFF_FFFE; then or, rd=3, result 0x0000_00F0, in consecutive cycles. in_ready stays 1 and the final reg3 is 0xF0. rs1=3 forwards each value in turn.
- Illegal funct 111111, rd=4: illegal_pulse is high for exactly one cycle, illegal_count=1 and reg4 is unchanged (0). The read on rs1=4 does not forward.
- Host conflict: a stage entry (and, rd=7, 0xA5) is pending while host_we=1 writes rd=7 with 0x11 for 2 cycles. in_ready is 0 during those cycles and rs2=7 reads 0xA5 via forwarding. The entry commits after the host write, and the final reg7 is 0xA5.
- rd=0 write of 0xDEAD_BEEF and a host write to address 0: rs1=0 always reads 0, and wb_count still increments for the pipeline write.
- Saturation with CNT_W=2: 5 legal commits give wb_count=3. Asynchronous reset asserted mid-transfer clears all state and the next read returns 0.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback/register-file block.
// Holds the funct codes, the result-slice index enum and the funct decoder.
package alu_wb_pkg;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Slice index into the packed result bus
  typedef enum logic [2:0] {
    SelAdd = 3'd0,
    SelSub = 3'd1,
    SelSrl = 3'd2,
    SelAnd = 3'd3,
    SelOr  = 3'd4,
    SelSlt = 3'd5
  } sel_e;

  // Returns {illegal, slice index}; index is SelAdd for illegal codes
  function automatic logic [3:0] decode_funct(input logic [5:0] funct);
    logic illegal;
    sel_e sel;
    illegal = 1'b0;
    sel     = SelAdd;
    case (funct)
      FUNCT_ADD: sel = SelAdd;
      FUNCT_SUB: sel = SelSub;
      FUNCT_SRL: sel = SelSrl;
      FUNCT_AND: sel = SelAnd;
      FUNCT_OR:  sel = SelOr;
      FUNCT_SLT: sel = SelSlt;
      default:   illegal = 1'b1;
    endcase
    return {illegal, sel};
  endfunction

endpackage

// File: rtl/alu_wb_regarray.sv
// Register storage: NUM_REGS x DATA_W, one write port, two asynchronous read ports.
// Register 0 always reads as zero and ignores writes.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (clears all registers)
//   we, waddr, wdata   write port
//   raddr1/rdata1      read port 1
//   raddr2/rdata2      read port 2
module alu_wb_regarray #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0) && (32'(waddr) < NUM_REGS)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if ((raddr1 != '0) && (32'(raddr1) < NUM_REGS)) rdata1 = regs[raddr1];
    if ((raddr2 != '0) && (32'(raddr2) < NUM_REGS)) rdata2 = regs[raddr2];
  end

endmodule

// File: rtl/alu_wb_regfile.sv
// ALU result select, single writeback stage and register file with forwarding.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             result bundle handshake
//   funct, rd, res_bus            function code, destination, packed results
//   host_we/host_addr/host_wdata  host write port, priority over pipeline commit
//   rs1_addr/rs1_data, rs2_*      forwarding read ports
//   illegal_pulse                 high in the cycle an illegal funct commits
//   wb_count, illegal_count       saturating event counters
module alu_wb_regfile
  import alu_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          funct,
  input  logic [ADDR_W-1:0]   rd,
  input  logic [6*DATA_W-1:0] res_bus,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [DATA_W-1:0]   rs1_data,
  output logic [DATA_W-1:0]   rs2_data,
  output logic                illegal_pulse,
  output logic [CNT_W-1:0]    wb_count,
  output logic [CNT_W-1:0]    illegal_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]        dec;
  logic              dec_illegal;
  sel_e              dec_sel;
  logic [DATA_W-1:0] dec_data;

  logic              s1_valid;
  logic              s1_illegal;
  logic [ADDR_W-1:0] s1_rd;
  logic [DATA_W-1:0] s1_data;

  logic commit;
  logic accept;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] arr_rdata1;
  logic [DATA_W-1:0] arr_rdata2;

  assign dec         = decode_funct(funct);
  assign dec_illegal = dec[3];
  assign dec_sel     = sel_e'(dec[2:0]);

  // Explicit slice mux so X on unselected slices cannot reach the stage
  always_comb begin
    dec_data = '0;
    if (!dec_illegal) begin
      case (dec_sel)
        SelAdd:  dec_data = res_bus[0*DATA_W +: DATA_W];
        SelSub:  dec_data = res_bus[1*DATA_W +: DATA_W];
        SelSrl:  dec_data = res_bus[2*DATA_W +: DATA_W];
        SelAnd:  dec_data = res_bus[3*DATA_W +: DATA_W];
        SelOr:   dec_data = res_bus[4*DATA_W +: DATA_W];
        SelSlt:  dec_data = res_bus[5*DATA_W +: DATA_W];
        default: dec_data = '0;
      endcase
    end
  end

  assign commit        = s1_valid && !host_we;
  assign in_ready      = !s1_valid || commit;
  assign accept        = in_valid && in_ready;
  assign illegal_pulse = commit && s1_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      s1_rd      <= '0;
      s1_data    <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_illegal <= dec_illegal;
      s1_rd      <= rd;
      s1_data    <= dec_data;
    end else if (commit) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_count      <= '0;
      illegal_count <= '0;
    end else if (commit) begin
      if (s1_illegal) begin
        if (illegal_count != CNT_MAX) illegal_count <= illegal_count + CNT_ONE;
      end else begin
        if (wb_count != CNT_MAX) wb_count <= wb_count + CNT_ONE;
      end
    end
  end

  // Host write wins the single array port; commit is already blocked while host_we is high.
  // Writes to r0 are filtered inside the array.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_rd;
    wr_data = s1_data;
    if (host_we) begin
      wr_en   = 1'b1;
      wr_addr = host_addr;
      wr_data = host_wdata;
    end else if (s1_valid && !s1_illegal) begin
      wr_en = 1'b1;
    end
  end

  alu_wb_regarray #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regarray (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_en),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .raddr1 (rs1_addr),
    .rdata1 (arr_rdata1),
    .raddr2 (rs2_addr),
    .rdata2 (arr_rdata2)
  );

  // Pending stage entry is forwarded even while stalled behind a host write
  always_comb begin
    rs1_data = arr_rdata1;
    rs2_data = arr_rdata2;
    if (rs1_addr == '0) begin
      rs1_data = '0;
    end else if (s1_valid && !s1_illegal && (s1_rd == rs1_addr)) begin
      rs1_data = s1_data;
    end
    if (rs2_addr == '0) begin
      rs2_data = '0;
    end else if (s1_valid && !s1_illegal && (s1_rd == rs2_addr)) begin
      rs2_data = s1_data;
    end
  end

endmodule

// File: tb/tb_alu_wb_regfile.sv
// Directed testbench for alu_wb_regfile. A second instance with CNT_W=2 shares the stimulus
// to exercise counter saturation.
module tb_alu_wb_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [5:0]          funct;
  logic [ADDR_W-1:0]   rd;
  logic [6*DATA_W-1:0] res_bus;
  logic                host_we;
  logic [ADDR_W-1:0]   host_addr;
  logic [DATA_W-1:0]   host_wdata;
  logic [ADDR_W-1:0]   rs1_addr;
  logic [ADDR_W-1:0]   rs2_addr;
  logic [DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]   rs2_data;
  logic                illegal_pulse;
  logic [15:0]         wb_count;
  logic [15:0]         illegal_count;

  logic                s_in_ready;
  logic [DATA_W-1:0]   s_rs1_data;
  logic [DATA_W-1:0]   s_rs2_data;
  logic                s_illegal_pulse;
  logic [1:0]          s_wb_count;
  logic [1:0]          s_illegal_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_wb_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (32),
    .ADDR_W   (ADDR_W),
    .CNT_W    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .funct         (funct),
    .rd            (rd),
    .res_bus       (res_bus),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .illegal_pulse (illegal_pulse),
    .wb_count      (wb_count),
    .illegal_count (illegal_count)
  );

  alu_wb_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (32),
    .ADDR_W   (ADDR_W),
    .CNT_W    (2)
  ) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (s_in_ready),
    .funct         (funct),
    .rd            (rd),
    .res_bus       (res_bus),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (s_rs1_data),
    .rs2_data      (s_rs2_data),
    .illegal_pulse (s_illegal_pulse),
    .wb_count      (s_wb_count),
    .illegal_count (s_illegal_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are driven
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample point in the middle of the current cycle
  task automatic sample();
    @(negedge clk);
  endtask

  // Result bus with a distinct filler in every slice and v in slice idx
  function automatic logic [6*DATA_W-1:0] make_bus(input int idx, input logic [DATA_W-1:0] v);
    logic [6*DATA_W-1:0] b;
    for (int k = 0; k < 6; k++) b[k*DATA_W +: DATA_W] = 32'hBAD0_0000 | DATA_W'(k);
    b[idx*DATA_W +: DATA_W] = v;
    return b;
  endfunction

  task automatic drive_bundle(input logic [5:0] f, input logic [ADDR_W-1:0] r,
                              input int idx, input logic [DATA_W-1:0] v);
    in_valid = 1'b1;
    funct    = f;
    rd       = r;
    res_bus  = make_bus(idx, v);
  endtask

  task automatic idle_bundle();
    in_valid = 1'b0;
    funct    = 6'b0;
    rd       = '0;
    res_bus  = '0;
  endtask

  initial begin
    rst        = 1'b1;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    rs1_addr   = '0;
    rs2_addr   = '0;
    idle_bundle();
    repeat (2) next_cycle();
    rst = 1'b0;
    rs1_addr = 5'd5;
    sample();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_rs1", 64'(rs1_data), 64'd0);
    check("reset_wb_count", 64'(wb_count), 64'd0);
    check("reset_illegal_count", 64'(illegal_count), 64'd0);
    check("reset_pulse", 64'(illegal_pulse), 64'd0);

    // add rd=5 -> 7: forwarded in N+1, from array in N+2
    next_cycle();
    drive_bundle(6'b100000, 5'd5, 0, 32'h0000_0007);
    sample();
    check("add_ready", 64'(in_ready), 64'd1);
    check("add_rs1_n", 64'(rs1_data), 64'd0);
    next_cycle();
    idle_bundle();
    sample();
    check("add_rs1_fwd", 64'(rs1_data), 64'd7);
    check("add_wb_n1", 64'(wb_count), 64'd0);
    next_cycle();
    sample();
    check("add_rs1_arr", 64'(rs1_data), 64'd7);
    check("add_wb_count", 64'(wb_count), 64'd1);

    // back-to-back sub then or to rd=3
    rs1_addr = 5'd3;
    next_cycle();
    drive_bundle(6'b100010, 5'd3, 1, 32'hFFFF_FFFE);
    sample();
    check("b2b_ready0", 64'(in_ready), 64'd1);
    next_cycle();
    drive_bundle(6'b100101, 5'd3, 4, 32'h0000_00F0);
    sample();
    check("b2b_ready1", 64'(in_ready), 64'd1);
    check("b2b_fwd_sub", 64'(rs1_data), 64'hFFFF_FFFE);
    next_cycle();
    idle_bundle();
    sample();
    check("b2b_fwd_or", 64'(rs1_data), 64'h0000_00F0);
    next_cycle();
    sample();
    check("b2b_reg3", 64'(rs1_data), 64'h0000_00F0);
    check("b2b_wb_count", 64'(wb_count), 64'd3);
    check("sat_wb_at3", 64'(s_wb_count), 64'd3);

    // illegal funct: one-cycle pulse, no write, no forward
    rs1_addr = 5'd4;
    next_cycle();
    drive_bundle(6'b111111, 5'd4, 0, 32'h9999_9999);
    sample();
    check("ill_pulse_n", 64'(illegal_pulse), 64'd0);
    next_cycle();
    idle_bundle();
    sample();
    check("ill_pulse_hi", 64'(illegal_pulse), 64'd1);
    check("ill_no_fwd", 64'(rs1_data), 64'd0);
    next_cycle();
    sample();
    check("ill_pulse_lo", 64'(illegal_pulse), 64'd0);
    check("ill_count", 64'(illegal_count), 64'd1);
    check("ill_reg4", 64'(rs1_data), 64'd0);
    check("ill_wb_count", 64'(wb_count), 64'd3);

    // host write to r7 for two cycles while an and-result for r7 is pending
    rs2_addr = 5'd7;
    next_cycle();
    drive_bundle(6'b100100, 5'd7, 3, 32'h0000_00A5);
    next_cycle();
    idle_bundle();
    host_we    = 1'b1;
    host_addr  = 5'd7;
    host_wdata = 32'h0000_0011;
    sample();
    check("host_ready0", 64'(in_ready), 64'd0);
    check("host_fwd0", 64'(rs2_data), 64'h0000_00A5);
    next_cycle();
    sample();
    check("host_ready1", 64'(in_ready), 64'd0);
    check("host_fwd1", 64'(rs2_data), 64'h0000_00A5);
    check("host_wb_hold", 64'(wb_count), 64'd3);
    next_cycle();
    host_we = 1'b0;
    sample();
    check("host_ready2", 64'(in_ready), 64'd1);
    check("host_fwd2", 64'(rs2_data), 64'h0000_00A5);
    next_cycle();
    sample();
    check("host_reg7", 64'(rs2_data), 64'h0000_00A5);
    check("host_wb_count", 64'(wb_count), 64'd4);

    // rd=0 pipeline write, host write to r0, host write to r9 not forwarded
    rs1_addr = 5'd0;
    next_cycle();
    drive_bundle(6'b100000, 5'd0, 0, 32'hDEAD_BEEF);
    next_cycle();
    idle_bundle();
    sample();
    check("r0_fwd", 64'(rs1_data), 64'd0);
    next_cycle();
    host_we    = 1'b1;
    host_addr  = 5'd0;
    host_wdata = 32'h0000_1234;
    sample();
    check("r0_wb_count", 64'(wb_count), 64'd5);
    check("sat_wb_count", 64'(s_wb_count), 64'd3);
    next_cycle();
    host_addr  = 5'd9;
    host_wdata = 32'h0000_0055;
    rs2_addr   = 5'd9;
    sample();
    check("r0_after_host", 64'(rs1_data), 64'd0);
    check("host9_not_fwd", 64'(rs2_data), 64'd0);
    next_cycle();
    host_we = 1'b0;
    sample();
    check("host9_visible", 64'(rs2_data), 64'h0000_0055);
    check("sat_ill_count", 64'(s_illegal_count), 64'd1);

    // asynchronous reset with an entry in flight
    rs1_addr = 5'd6;
    rs2_addr = 5'd5;
    next_cycle();
    drive_bundle(6'b100000, 5'd6, 0, 32'h0000_0077);
    next_cycle();
    idle_bundle();
    #1;
    check("rst_pre_fwd", 64'(rs1_data), 64'h0000_0077);
    #1;
    rst = 1'b1;
    #1;
    check("rst_rs1", 64'(rs1_data), 64'd0);
    check("rst_rs2", 64'(rs2_data), 64'd0);
    check("rst_wb_count", 64'(wb_count), 64'd0);
    check("rst_ill_count", 64'(illegal_count), 64'd0);
    next_cycle();
    rst = 1'b0;
    rs2_addr = 5'd3;
    sample();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_reg6", 64'(rs1_data), 64'd0);
    check("rst_reg3", 64'(rs2_data), 64'd0);
    check("rst_sat_wb", 64'(s_wb_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
